// File: rtl/mvau_stream_feeder.sv
// -----------------------------------------------------------------------------
// mvau_stream_feeder
//
// Transmit-side sequencer for mvau_stream. One activation vector (SF beats of
// SIMD lanes) is collected from a valid/ready stream into one bank of a
// ping-pong buffer. While the other bank fills, the full bank is replayed NF
// times. Each replayed beat is paired with the matching PE x SIMD weight tile
// fetched from an external synchronous weight memory. Beats come out in the
// order mvau_stream consumes them: sf inner, nf outer.
//
// Ports
//   clk        sole clock, rising edge
//   rst        asynchronous, active-high reset
//   s_valid    upstream activation beat valid
//   s_ready    feeder can accept a beat (0 while rst is high)
//   s_act      activation beat, lane k at bits [k*TSrcI +: TSrcI]
//   wgt_ren    weight memory read enable (high in the cycle a beat issues)
//   wgt_addr   weight tile address, nf*SF + sf
//   wgt_rdata  weight tile, valid one cycle after wgt_ren, held while wgt_ren=0
//   m_valid    output beat valid
//   m_ready    downstream accepts the output beat
//   in_act     activation word to the MVAU (registered)
//   in_wgt     weight tile to the MVAU (wired straight from wgt_rdata)
// -----------------------------------------------------------------------------
module mvau_stream_feeder #(
  parameter int SIMD    = 2,
  parameter int PE      = 2,
  parameter int TSrcI   = 4,
  parameter int TW      = 1,
  parameter int MatrixW = 4,
  parameter int MatrixH = 4,
  localparam int SF     = MatrixW / SIMD,
  localparam int NF     = MatrixH / PE,
  localparam int ADDR_W = (NF * SF > 1) ? $clog2(NF * SF) : 1
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            s_valid,
  output logic                            s_ready,
  input  logic [SIMD*TSrcI-1:0]           s_act,
  output logic                            wgt_ren,
  output logic [ADDR_W-1:0]               wgt_addr,
  input  logic [PE*SIMD*TW-1:0]           wgt_rdata,
  output logic                            m_valid,
  input  logic                            m_ready,
  output logic [0:SIMD-1][TSrcI-1:0]      in_act,
  output logic [0:PE-1][0:SIMD-1][TW-1:0] in_wgt
);

  localparam int ACT_W = SIMD * TSrcI;
  localparam int SF_W  = (SF > 1) ? $clog2(SF) : 1;
  localparam int NF_W  = (NF > 1) ? $clog2(NF) : 1;

  localparam logic [SF_W-1:0] SF_LAST = SF_W'(SF - 1);
  localparam logic [NF_W-1:0] NF_LAST = NF_W'(NF - 1);

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  // Write side
  logic            wr_bank_q, wr_bank_d;
  logic [SF_W-1:0] wr_sf_q,   wr_sf_d;
  // One full flag per bank; the only coupling between write and read sides
  logic [1:0]      full_q,    full_d;
  // Read side
  logic            rd_bank_q, rd_bank_d;
  logic [SF_W-1:0] rd_sf_q,   rd_sf_d;
  logic [NF_W-1:0] rd_nf_q,   rd_nf_d;
  logic [ACT_W-1:0] in_act_q, in_act_d;
  logic            m_valid_q, m_valid_d;

  // Ping-pong activation buffer: two banks of SF words
  logic [ACT_W-1:0] act_buf [2][SF];

  logic wr_en;
  logic adv;
  logic issue;

  // ---------------------------------------------------------------------------
  // Handshake and weight fetch
  // ---------------------------------------------------------------------------
  // The weight read is combinational from the issue decision so that the tile
  // lands on wgt_rdata in the same cycle the registered in_act appears, keeping
  // in_act and in_wgt aligned without an extra pipeline stage.
  always_comb begin
    s_ready  = !rst && !full_q[wr_bank_q];
    wr_en    = s_valid && s_ready;
    // The output register may load whenever it is empty or being drained.
    adv      = !m_valid_q || m_ready;
    issue    = adv && full_q[rd_bank_q];
    wgt_ren  = issue;
    // Driven from the counters at all times so it stays stable during a stall.
    wgt_addr = ADDR_W'(rd_nf_q) * ADDR_W'(SF) + ADDR_W'(rd_sf_q);
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves one unassigned
    // and a latch is never inferred.
    wr_bank_d = wr_bank_q;
    wr_sf_d   = wr_sf_q;
    full_d    = full_q;
    rd_bank_d = rd_bank_q;
    rd_sf_d   = rd_sf_q;
    rd_nf_d   = rd_nf_q;
    in_act_d  = in_act_q;
    m_valid_d = m_valid_q;

    // Fill: the last word of a vector marks the bank full and flips banks.
    if (wr_en) begin
      if (wr_sf_q == SF_LAST) begin
        wr_sf_d           = '0;
        wr_bank_d         = !wr_bank_q;
        full_d[wr_bank_q] = 1'b1;
      end else begin
        wr_sf_d = wr_sf_q + 1'b1;
      end
    end

    // Replay: sf inner, nf outer. The set above and the clear below can never
    // target the same bank: writes only go to an empty bank, reads only come
    // from a full one.
    if (issue) begin
      in_act_d  = act_buf[rd_bank_q][rd_sf_q];
      m_valid_d = 1'b1;
      if (rd_sf_q == SF_LAST) begin
        rd_sf_d = '0;
        if (rd_nf_q == NF_LAST) begin
          rd_nf_d           = '0;
          rd_bank_d         = !rd_bank_q;
          full_d[rd_bank_q] = 1'b0;
        end else begin
          rd_nf_d = rd_nf_q + 1'b1;
        end
      end else begin
        rd_sf_d = rd_sf_q + 1'b1;
      end
    end else if (adv) begin
      // Beat drained (or never present) and nothing to replay: go idle.
      m_valid_d = 1'b0;
    end
    // !adv: output stalled, everything on the read side holds.
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values of the others regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_bank_q <= 1'b0;
      wr_sf_q   <= '0;
      full_q    <= '0;
      rd_bank_q <= 1'b0;
      rd_sf_q   <= '0;
      rd_nf_q   <= '0;
      in_act_q  <= '0;
      m_valid_q <= 1'b0;
    end else begin
      wr_bank_q <= wr_bank_d;
      wr_sf_q   <= wr_sf_d;
      full_q    <= full_d;
      rd_bank_q <= rd_bank_d;
      rd_sf_q   <= rd_sf_d;
      rd_nf_q   <= rd_nf_d;
      in_act_q  <= in_act_d;
      m_valid_q <= m_valid_d;
    end
  end

  // NOTE: the buffer storage has no reset. A bank is only read after its full
  // flag is set, which requires every word of it to have been written first,
  // so stale contents are never observable.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      act_buf[wr_bank_q][wr_sf_q] <= s_act;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign m_valid = m_valid_q;
  assign in_act  = in_act_q;
  assign in_wgt  = wgt_rdata;

endmodule
